// File: rtl/banked_main_mem_pkg.sv
// Shared parameters and address-field helpers for the four-bank interleaved main memory.
// The cache controller imports the same package so both sides agree on bank/row slicing.
package banked_main_mem_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int NUM_BANKS  = 4;
    localparam int BANK_W     = 2;
    localparam int BANK_WORDS = 8192;
    localparam int BUSY_CYC   = 4;
    localparam int RD_LAT     = 2;
    localparam int CNT_W      = 2;

    localparam int BANK_LSB   = 1;
    localparam int ROW_LSB    = 3;
    localparam int ROW_W      = ADDR_W - ROW_LSB;

    // Consecutive words of a line land in consecutive banks.
    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ROW_LSB-1:BANK_LSB];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ROW_LSB];
    endfunction

endpackage

// File: rtl/banked_main_mem_if.sv
// Request/response bus between the cache controller (master) and main memory (slave).
interface banked_main_mem_if;
    import banked_main_mem_pkg::*;

    logic [ADDR_W-1:0]    Addr;
    logic [DATA_W-1:0]    DataIn;
    logic                 Rd;
    logic                 Wr;
    logic [DATA_W-1:0]    DataOut;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, stall, busy, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, stall, busy, err
    );

endinterface

// File: rtl/banked_main_mem_mem_bank.sv
// One memory bank: word storage, occupancy counter and the first read pipeline stage.
// Storage is deliberately left out of reset so contents survive a controller reset.
module mem_bank
    import banked_main_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              acc,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [BANK_WORDS];
    logic [CNT_W-1:0]  cnt;
    logic              re;

    assign re   = acc & ~we;
    assign busy = (cnt != '0);

    // Writes commit even in a reset cycle; only control state is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[row] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (acc) begin
            cnt <= CNT_W'(BUSY_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
        end
        if (re) begin
            rd_data <= mem[row];
        end
    end

endmodule

// File: rtl/banked_main_mem.sv
// Four-bank interleaved main memory: request decode, stall/err generation and the
// second read pipeline stage that gives a fixed two-cycle read latency.
module banked_main_mem
    import banked_main_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    banked_main_mem_if.slave  bus
);

    logic [BANK_W-1:0]    bank;
    logic [ROW_W-1:0]     row;
    logic                 req;
    logic                 accept;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [NUM_BANKS-1:0] rd_valid_vec;
    logic [DATA_W-1:0]    rd_data_arr [NUM_BANKS];
    logic                 sel_valid;
    logic [DATA_W-1:0]    sel_data;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;

    assign bank = bank_of(bus.Addr);
    assign row  = row_of(bus.Addr);
    assign req  = bus.Rd ^ bus.Wr;

    assign bus.err   = (bus.Rd & bus.Wr) | ((bus.Rd | bus.Wr) & bus.Addr[0]);
    assign bus.stall = req & busy_vec[bank];
    assign bus.busy  = busy_vec;
    assign accept    = req & ~bus.stall & ~bus.err;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic acc_b;
        assign acc_b = accept && (bank == BANK_W'(b));

        mem_bank u_bank (
            .clk      (clk),
            .rst      (rst),
            .acc      (acc_b),
            .we       (acc_b & bus.Wr),
            .row      (row),
            .wdata    (bus.DataIn),
            .busy     (busy_vec[b]),
            .rd_valid (rd_valid_vec[b]),
            .rd_data  (rd_data_arr[b])
        );
    end

    // At most one bank can hold a valid read, since only one request is accepted per cycle.
    always_comb begin
        sel_valid = |rd_valid_vec;
        sel_data  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_valid_vec[b]) begin
                sel_data = rd_data_arr[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= sel_valid;
        end
        out_data <= sel_data;
    end

    assign bus.DataOut = out_valid ? out_data : '0;

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed scoreboard bench: the driver queues expected read data with its return cycle,
// and a monitor compares DataOut every cycle (zero when nothing is due).
module tb_banked_main_mem;
    import banked_main_mem_pkg::*;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    bit   monitor_en;
    exp_t exp_q[$];

    banked_main_mem_if bus();

    banked_main_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: DataOut must equal the queued word in its due cycle and be zero otherwise.
    always @(negedge clk) begin
        if (monitor_en) begin
            tests++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.DataOut !== e.data) begin
                    fails++;
                    $display("[TB] FAIL dataout@%0d: got %h expected %h", cyc, bus.DataOut, e.data);
                end
            end else if (bus.DataOut !== 16'h0000) begin
                fails++;
                $display("[TB] FAIL idle_dataout@%0d: got %h expected 0000", cyc, bus.DataOut);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] data);
        @(posedge clk);
        #1;
        rst        = r;
        bus.Rd     = rd;
        bus.Wr     = wr;
        bus.Addr   = addr;
        bus.DataIn = data;
    endtask

    task automatic checkOutput(input string name, input logic exp_stall, input logic exp_err,
                               input logic [3:0] exp_busy, input logic push,
                               input logic [15:0] exp_data);
        @(negedge clk);
        tests += 3;
        if (bus.stall !== exp_stall) begin
            fails++;
            $display("[TB] FAIL %s stall: got %b expected %b", name, bus.stall, exp_stall);
        end
        if (bus.err !== exp_err) begin
            fails++;
            $display("[TB] FAIL %s err: got %b expected %b", name, bus.err, exp_err);
        end
        if (bus.busy !== exp_busy) begin
            fails++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, bus.busy, exp_busy);
        end
        if (push) exp_q.push_back('{cyc + RD_LAT, exp_data});
    endtask

    task automatic op(input string name, input logic r, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [15:0] data,
                      input logic exp_stall, input logic exp_err, input logic [3:0] exp_busy,
                      input logic push, input logic [15:0] exp_data);
        applyStimulus(r, rd, wr, addr, data);
        checkOutput(name, exp_stall, exp_err, exp_busy, push, exp_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] fill_addr [4];
        logic [15:0] fill_data [4];
        logic [3:0]  fill_busy [4];
        fill_addr = '{16'h0040, 16'h0042, 16'h0044, 16'h0046};
        fill_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        fill_busy = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        cyc = 0; tests = 0; fails = 0; monitor_en = 1'b0;
        rst = 1'b1;
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0;

        repeat (2) @(posedge clk);
        checkOutput("reset", 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0);
        tests++;
        if (bus.DataOut !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset dataout: got %h expected 0000", bus.DataOut);
        end
        monitor_en = 1'b1;

        // Preload words that later reads depend on.
        for (int i = 0; i < 4; i++)
            op("preload_line", 0, 0, 1, fill_addr[i], fill_data[i], 0, 0, fill_busy[i], 0, 16'h0);
        idle(4);
        op("preload_100", 0, 0, 1, 16'h0100, 16'hA5A5, 0, 0, 4'b0000, 0, 16'h0);
        idle(4);
        op("preload_108", 0, 0, 1, 16'h0108, 16'h5A5A, 0, 0, 4'b0000, 0, 16'h0);
        idle(4);
        op("preload_020", 0, 0, 1, 16'h0020, 16'h1234, 0, 0, 4'b0000, 0, 16'h0);
        idle(4);

        // Write then read back once the bank frees.
        op("t1_wr",   0, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 0, 16'h0);
        op("t1_gap1", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0);
        op("t1_gap2", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0);
        op("t1_gap3", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0);
        op("t1_rd",   0, 1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 1, 16'hBEEF);
        idle(4);

        // Line fill, one word per cycle across the four banks.
        for (int i = 0; i < 4; i++)
            op("t2_fill", 0, 1, 0, fill_addr[i], 16'h0, 0, 0, fill_busy[i], 1, fill_data[i]);
        idle(4);

        // Same-bank read conflict.
        op("t3_rd0", 0, 1, 0, 16'h0100, 16'h0, 0, 0, 4'b0000, 1, 16'hA5A5);
        for (int i = 0; i < 3; i++)
            op("t3_stall", 0, 1, 0, 16'h0108, 16'h0, 1, 0, 4'b0001, 0, 16'h0);
        op("t3_rd1", 0, 1, 0, 16'h0108, 16'h0, 0, 0, 4'b0000, 1, 16'h5A5A);
        idle(4);

        // Illegal requests are dropped entirely.
        op("t4_rdwr",  0, 1, 1, 16'h0020, 16'hFFFF, 0, 1, 4'b0000, 0, 16'h0);
        op("t4_misrd", 0, 1, 0, 16'h0021, 16'h0000, 0, 1, 4'b0000, 0, 16'h0);
        op("t4_miswr", 0, 0, 1, 16'h0021, 16'hFFFF, 0, 1, 4'b0000, 0, 16'h0);
        op("t4_idle",  0, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0);
        op("t4_rd",    0, 1, 0, 16'h0020, 16'h0000, 0, 0, 4'b0000, 1, 16'h1234);
        idle(4);

        // Reset discards an in-flight read and frees the bank immediately.
        op("t5_rd",   0, 1, 0, 16'h0200, 16'h0, 0, 0, 4'b0000, 0, 16'h0);
        op("t5_rst",  1, 0, 0, 16'h0000, 16'h0, 0, 0, 4'b0001, 0, 16'h0);
        op("t5_rd2",  0, 1, 0, 16'h0040, 16'h0, 0, 0, 4'b0000, 1, 16'h1111);
        idle(4);
        op("t5_wrst", 1, 0, 1, 16'h0030, 16'hCAFE, 0, 0, 4'b0000, 0, 16'h0);
        idle(4);
        op("t5_rdw",  0, 1, 0, 16'h0030, 16'h0, 0, 0, 4'b0000, 1, 16'hCAFE);
        idle(4);

        // Interleaved write-back followed by reads of the new data.
        op("t6_wr0", 0, 0, 1, 16'h0300, 16'h0A0A, 0, 0, 4'b0000, 0, 16'h0);
        op("t6_wr1", 0, 0, 1, 16'h0302, 16'h0B0B, 0, 0, 4'b0001, 0, 16'h0);
        op("t6_wr2", 0, 0, 1, 16'h0304, 16'h0C0C, 0, 0, 4'b0011, 0, 16'h0);
        op("t6_wr3", 0, 0, 1, 16'h0306, 16'h0D0D, 0, 0, 4'b0111, 0, 16'h0);
        op("t6_rd0", 0, 1, 0, 16'h0300, 16'h0,    0, 0, 4'b1110, 1, 16'h0A0A);
        op("t6_rd1", 0, 1, 0, 16'h0302, 16'h0,    0, 0, 4'b1101, 1, 16'h0B0B);
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
